// File: rtl/instmem_fetch_ctrl_if.sv
// instmem_fetch_ctrl_if: instruction-memory read bus plus decode valid/ready handshake
// master (fetch controller): drives mem_addr, inst, inst_valid; samples mem_data, inst_ready
// slave (memory + decode side): the mirror image
interface instmem_fetch_ctrl_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int INST_LENGTH = 8
);
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INST_LENGTH-1:0] mem_data;
  logic [INST_LENGTH-1:0] inst;
  logic                   inst_valid;
  logic                   inst_ready;
  modport master (output mem_addr, inst, inst_valid, input mem_data, inst_ready);
  modport slave  (input mem_addr, inst, inst_valid, output mem_data, inst_ready);
endinterface

// File: rtl/instmem_fetch_ctrl.sv
// instmem_fetch_ctrl: PC sequencer feeding a single-entry instruction register to decode
// ports: clk, rst_n (async active-low); start/start_addr launch a program from IDLE;
// bus carries mem_addr/mem_data and the inst/inst_valid/inst_ready handshake;
// branch_valid/branch_target redirect the PC; running, done, inst_count report progress
module instmem_fetch_ctrl #(
  parameter int                     ADDR_WIDTH  = 6,
  parameter int                     INST_LENGTH = 8,
  parameter logic [INST_LENGTH-1:0] HALT_OPCODE = 8'hFF,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  running,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  inst_count,
  instmem_fetch_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  pc, pc_n;
  logic [INST_LENGTH-1:0] inst, inst_n;
  logic                   valid, valid_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic                   xfer, free;
  assign bus.mem_addr   = pc;
  assign bus.inst       = inst;
  assign bus.inst_valid = valid;
  assign running        = state == RUN || state == DRAIN;
  assign done           = state == FIN;
  assign inst_count     = cnt;
  // a redirect squashes the held instruction, so it never counts as a transfer
  assign xfer = valid && bus.inst_ready && !branch_valid;
  assign free = !valid || xfer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      inst  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      inst  <= inst_n;
      valid <= valid_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst;
    valid_n = valid && !xfer;
    cnt_n   = (xfer && cnt != '1) ? cnt + 1'b1 : cnt;
    case (state)
      IDLE: if (start) begin
        pc_n    = start_addr;
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: if (branch_valid) begin
        valid_n = 1'b0;
        pc_n    = branch_target;
      end else if (free) begin
        inst_n  = bus.mem_data;
        valid_n = 1'b1;
        // the PC parks on the halt word so mem_addr shows where the program ended
        state_n = bus.mem_data == HALT_OPCODE ? DRAIN : RUN;
        pc_n    = bus.mem_data == HALT_OPCODE ? pc : pc + 1'b1;
      end
      DRAIN: if (branch_valid) begin
        valid_n = 1'b0;
        pc_n    = branch_target;
        state_n = RUN;
      end else if (xfer) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end
endmodule
